byte_reg_sequencer: RTL

Sequences a byte stream into a bank of `NUM_WORDS` 32-bit byte-enabled registers, one byte write per accepted byte. It generates word index, byte select and write enable so that SD response and argument registers can be filled one byte at a time. It sits between the byte-wide serial shifter and the register bank. It owns the byte ordering, completion signalling and optional stall timeout.

---
 rtl/byte_reg_sequencer_if.sv | 28 ++
 rtl/byte_reg_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/byte_reg_sequencer_if.sv
// Byte stream input plus byte-write port toward the register bank.
// The sequencer uses the slave modport; the shifter/bank side uses master.
interface byte_reg_sequencer_if #(
  parameter int WW = 2
);
  // Byte stream from the serial shifter
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;

  // Byte-enabled write toward the register bank
  logic          reg_we;
  logic [WW-1:0] reg_word;
  logic [1:0]    reg_byte_sel;
  logic [7:0]    reg_byte_in;

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  reg_we, reg_word, reg_byte_sel, reg_byte_in
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output reg_we, reg_word, reg_byte_sel, reg_byte_in
  );
endinterface

// File: rtl/byte_reg_sequencer.sv
// byte_reg_sequencer: turns an accepted byte stream into one byte-lane write
// per byte across NUM_WORDS 32-bit registers, in MSB-first or LSB-first order.
// Optional LOAD stall timeout is compiled in with `define BYTE_SEQ_TIMEOUT_EN;
// without it LOAD waits indefinitely and error is constant 0.
module byte_reg_sequencer #(
  parameter int NUM_WORDS      = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LW             = $clog2(4 * NUM_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LW-1:0]        len,
  input  logic                 abort,
  byte_reg_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int MAXB = 4 * NUM_WORDS;
  localparam int WW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [LW-1:0] len_q;      // clipped transfer length L
  logic [LW-1:0] idx_q;      // index of the next byte to accept
  logic [LW-1:0] len_clip;
  logic [LW-1:0] pos;        // byte position of the current byte in the transfer
  logic          hs;
  logic          last;
  logic          timeout;

  logic          we_q;
  logic [WW-1:0] word_q;
  logic [1:0]    sel_q;
  logic [7:0]    data_q;

  assign len_clip = (len > LW'(MAXB)) ? LW'(MAXB) : len;
  assign hs       = bus.s_valid && bus.s_ready;
  assign last     = (idx_q == len_q - 1'b1);
  assign pos      = MSB_FIRST ? (len_q - 1'b1 - idx_q) : idx_q;

  // State register
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and state-decoded outputs; abort beats everything in LOAD/DRAIN
  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    bus.s_ready = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    unique case (state)
      IDLE: begin
        if (start) state_nx = (len_clip == '0) ? DONE : LOAD;
      end
      LOAD: begin
        bus.s_ready = !abort;
        if (abort)            state_nx = IDLE;
        else if (timeout)     state_nx = IDLE;
        else if (hs && last)  state_nx = DRAIN;
      end
      DRAIN: begin
        state_nx = abort ? IDLE : DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Length latch and byte index; the index only moves on an accepted byte
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q <= '0;
      idx_q <= '0;
    end else if (state == IDLE && start) begin
      len_q <= len_clip;
      idx_q <= '0;
    end else if (hs) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Registered write port: one strobe per accepted byte, address/data held
  // between strobes so the bank sees stable values
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q   <= 1'b0;
      word_q <= '0;
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      we_q <= hs;
      if (hs) begin
        word_q <= WW'(pos >> 2);
        sel_q  <= pos[1:0];
        data_q <= bus.s_data;
      end
    end
  end

  assign bus.reg_we       = we_q;
  assign bus.reg_word     = word_q;
  assign bus.reg_byte_sel = sel_q;
  assign bus.reg_byte_in  = data_q;

`ifdef BYTE_SEQ_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  logic [GW-1:0] gap_q;
  logic          error_q;

  // Fires on the cycle that would bring the gap count to TIMEOUT_CYCLES;
  // an abort in the same cycle takes precedence and leaves error clear.
  assign timeout = (state == LOAD) && !hs && !abort &&
                   (gap_q == GW'(TIMEOUT_CYCLES - 1));

  // Consecutive LOAD cycles without an accepted byte
  always_ff @(posedge clk) begin
    if (!rst)                     gap_q <= '0;
    else if (state != LOAD || hs) gap_q <= '0;
    else                          gap_q <= gap_q + 1'b1;
  end

  // Sticky timeout flag, cleared only by an accepted start or reset
  always_ff @(posedge clk) begin
    if (!rst)                        error_q <= 1'b0;
    else if (state == IDLE && start) error_q <= 1'b0;
    else if (timeout)                error_q <= 1'b1;
  end

  assign error = error_q;
`else
  // Without the timeout option the limit has no effect; it is kept so the
  // parameter list is identical in both builds.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule
